// File: rtl/ps2_key_ctrl.sv
// Pops PS/2 scan-code bytes from the keyboard FIFO, strips E0/F0 prefixes,
// tracks the held key, counts distinct presses and pulses code_vld per event.
module ps2_key_ctrl #(
   parameter int         CNT_W      = 8,
   parameter logic [7:0] BREAK_CODE = 8'hF0,
   parameter logic [7:0] EXT_CODE   = 8'hE0
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             ready,
   input  logic [7:0]       data,
   input  logic             overflow,
   input  logic             clr,
   output logic             nextdata_n,
   output logic [7:0]       scan_code,
   output logic             key_ext,
   output logic             key_down,
   output logic             code_vld,
   output logic [CNT_W-1:0] press_cnt,
   output logic             ovf_sticky,
   output logic [1:0]       dbg_state
);

   // Handshake: a byte is taken when ready=1 in S_IDLE; nextdata_n is then
   // held low for exactly the S_ACK cycle, and S_GAP lets ready/data settle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t             state_q;
   logic [7:0]         rx_q;
   logic               ext_pend_q;
   logic               brk_pend_q;
   logic [7:0]         scan_code_q;
   logic               key_ext_q;
   logic               key_down_q;
   logic               code_vld_q;
   logic               nextdata_n_q;
   logic [CNT_W-1:0]   press_cnt_q;
   logic [CNT_W-1:0]   press_cnt_d;
   logic               ovf_sticky_q;
   logic               ovf_sticky_d;

   logic               is_ext;
   logic               is_brk;
   logic               held_match;
   logic               make_evt;
   logic               brk_evt;

   always_comb begin
      is_ext     = (rx_q == EXT_CODE);
      is_brk     = (rx_q == BREAK_CODE);
      held_match = key_down_q && ({ext_pend_q, rx_q} == {key_ext_q, scan_code_q});
      make_evt   = (state_q == S_GAP) && !is_ext && !is_brk && !brk_pend_q && !held_match;
      brk_evt    = (state_q == S_GAP) && !is_ext && !is_brk &&  brk_pend_q &&  held_match;
   end

   // Soft clear wins over a same-cycle press or overflow.
   always_comb begin
      press_cnt_d  = press_cnt_q;
      ovf_sticky_d = ovf_sticky_q | overflow;
      if (make_evt) begin
         press_cnt_d = press_cnt_q + 1'b1;
      end
      if (clr) begin
         press_cnt_d  = '0;
         ovf_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= S_IDLE;
         rx_q         <= 8'h00;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         scan_code_q  <= 8'h00;
         key_ext_q    <= 1'b0;
         key_down_q   <= 1'b0;
         code_vld_q   <= 1'b0;
         nextdata_n_q <= 1'b1;
         press_cnt_q  <= '0;
         ovf_sticky_q <= 1'b0;
      end else begin
         code_vld_q   <= 1'b0;
         press_cnt_q  <= press_cnt_d;
         ovf_sticky_q <= ovf_sticky_d;
         case (state_q)
            S_IDLE: begin
               nextdata_n_q <= 1'b1;
               if (ready) begin
                  rx_q         <= data;
                  nextdata_n_q <= 1'b0;
                  state_q      <= S_ACK;
               end
            end
            S_ACK: begin
               nextdata_n_q <= 1'b1;
               state_q      <= S_GAP;
            end
            S_GAP: begin
               nextdata_n_q <= 1'b1;
               state_q      <= S_IDLE;
               if (is_ext) begin
                  ext_pend_q <= 1'b1;
               end else if (is_brk) begin
                  brk_pend_q <= 1'b1;
               end else begin
                  ext_pend_q <= 1'b0;
                  brk_pend_q <= 1'b0;
                  if (make_evt) begin
                     scan_code_q <= rx_q;
                     key_ext_q   <= ext_pend_q;
                     key_down_q  <= 1'b1;
                     code_vld_q  <= 1'b1;
                  end else if (brk_evt) begin
                     key_down_q  <= 1'b0;
                     code_vld_q  <= 1'b1;
                  end
               end
            end
            default: begin
               nextdata_n_q <= 1'b1;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign nextdata_n = nextdata_n_q;
   assign scan_code  = scan_code_q;
   assign key_ext    = key_ext_q;
   assign key_down   = key_down_q;
   assign code_vld   = code_vld_q;
   assign press_cnt  = press_cnt_q;
   assign ovf_sticky = ovf_sticky_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: behavioural FIFO feeds bytes, expected key events
// are queued as bytes are pushed and compared whenever code_vld pulses.
module tb_ps2_key_ctrl;

   localparam int W = 18;   // {scan_code, key_ext, key_down, press_cnt}

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] data = 8'h00;
   logic       overflow = 1'b0;
   logic       clr = 1'b0;
   logic       nextdata_n;
   logic [7:0] scan_code;
   logic       key_ext;
   logic       key_down;
   logic       code_vld;
   logic [7:0] press_cnt;
   logic       ovf_sticky;
   logic [1:0] dbg_state;

   ps2_key_ctrl #(.CNT_W(8), .BREAK_CODE(8'hF0), .EXT_CODE(8'hE0)) dut (
      .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
      .clr(clr), .nextdata_n(nextdata_n), .scan_code(scan_code), .key_ext(key_ext),
      .key_down(key_down), .code_vld(code_vld), .press_cnt(press_cnt),
      .ovf_sticky(ovf_sticky), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [7:0]   fifo_q[$];
   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int push_cnt = 0;
   int pop_cnt = 0;
   logic prev_low = 1'b0;
   logic prev_vld = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ev(input logic [7:0] c, input logic e,
                                       input logic d, input logic [7:0] n);
      return {c, e, d, n};
   endfunction

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      push_cnt++;
      ready = 1'b1;
      data  = fifo_q[0];
   endtask

   // FIFO model: a low nextdata_n pops the head byte.
   always @(negedge clk) begin
      if (clrn && !nextdata_n) begin
         chk("pop_pulse_width", {31'd0, prev_low}, 32'd0);
         chk("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         pop_cnt++;
         ready = (fifo_q.size() != 0);
         data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      end
      prev_low = clrn && !nextdata_n;
   end

   // Event monitor.
   always @(negedge clk) begin
      if (code_vld) begin
         chk("code_vld_single", {31'd0, prev_vld}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {14'd0, scan_code, key_ext, key_down, press_cnt}, 32'h3FFFF);
         end else begin
            chk("event", {14'd0, scan_code, key_ext, key_down, press_cnt},
                {14'd0, exp_q.pop_front()});
         end
      end
      prev_vld = code_vld;
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!(fifo_q.size() == 0 && dbg_state == 2'd0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      if (n >= budget) chk({name, "_timeout"}, n, 0);
      chk({name, "_exp_left"}, exp_q.size(), 0);
      chk({name, "_pops"}, pop_cnt, push_cnt);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         rst_before;
      logic [7:0]   b;
      logic         has_ev;
      logic [W-1:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic [7:0] b, input logic h,
                               input logic [W-1:0] e);
      vec_t v;
      v.rst_before = r; v.b = b; v.has_ev = h; v.exp = e;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] code;
      int n;

      // make / break of a plain key
      add(1, 8'h1C, 1, ev(8'h1C, 0, 1, 8'd1));
      add(0, 8'hF0, 0, '0);
      add(0, 8'h1C, 1, ev(8'h1C, 0, 0, 8'd1));
      // extended key with typematic repeats, then its break
      add(1, 8'hE0, 0, '0);
      add(0, 8'h75, 1, ev(8'h75, 1, 1, 8'd1));
      add(0, 8'hE0, 0, '0);
      add(0, 8'h75, 0, '0);
      add(0, 8'hE0, 0, '0);
      add(0, 8'h75, 0, '0);
      add(0, 8'hE0, 0, '0);
      add(0, 8'hF0, 0, '0);
      add(0, 8'h75, 1, ev(8'h75, 1, 0, 8'd1));
      // breaks of unheld keys are ignored, ext must match too
      add(1, 8'h1C, 1, ev(8'h1C, 0, 1, 8'd1));
      add(0, 8'hF0, 0, '0);
      add(0, 8'h32, 0, '0);
      add(0, 8'hE0, 0, '0);
      add(0, 8'hF0, 0, '0);
      add(0, 8'h1C, 0, '0);
      add(0, 8'hF0, 0, '0);
      add(0, 8'h1C, 1, ev(8'h1C, 0, 0, 8'd1));
      add(0, 8'h1C, 1, ev(8'h1C, 0, 1, 8'd2));

      // ---- reset in the middle of the pop cycle ----
      do_reset();
      chk("rst_nextdata_n", {31'd0, nextdata_n}, 32'd1);
      chk("rst_outputs", {scan_code, key_ext, key_down, code_vld, press_cnt, ovf_sticky},
          32'd0);
      push_byte(8'h1C);
      n = 0;
      @(posedge clk); #1;
      while (nextdata_n && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ack_seen", {31'd0, nextdata_n}, 32'd0);
      clrn = 1'b0;
      #1;
      chk("midack_nextdata_n", {31'd0, nextdata_n}, 32'd1);
      chk("midack_outputs", {scan_code, key_ext, key_down, code_vld, press_cnt, ovf_sticky},
          32'd0);
      chk("midack_state", {30'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      chk("midack_fifo_kept", fifo_q.size(), 1);
      clrn = 1'b1;
      exp_q.push_back(ev(8'h1C, 0, 1, 8'd1));
      wait_drain("midack_release", 100);

      // ---- table-driven streams ----
      foreach (tbl[i]) begin
         if (tbl[i].rst_before) begin
            wait_drain("table_seg", 400);
            do_reset();
         end
         push_byte(tbl[i].b);
         if (tbl[i].has_ev) exp_q.push_back(tbl[i].exp);
      end
      wait_drain("table_end", 400);
      chk("held_after_table", {31'd0, key_down}, 32'd1);

      // ---- press counter wrap ----
      do_reset();
      for (int i = 0; i < 255; i++) begin
         code = 8'($urandom_range(8'h01, 8'h7F));
         push_byte(code);
         exp_q.push_back(ev(code, 0, 1, 8'(i + 1)));
         push_byte(8'hF0);
         push_byte(code);
         exp_q.push_back(ev(code, 0, 0, 8'(i + 1)));
      end
      wait_drain("wrap_fill", 6000);
      chk("cnt_ff", {24'd0, press_cnt}, 32'hFF);
      push_byte(8'h4B);
      exp_q.push_back(ev(8'h4B, 0, 1, 8'h00));
      wait_drain("wrap_zero", 100);
      chk("cnt_wrapped", {24'd0, press_cnt}, 32'h00);

      // ---- overflow sticky and clear priority ----
      do_reset();
      @(negedge clk); overflow = 1'b1;
      @(negedge clk); overflow = 1'b0;
      @(negedge clk);
      chk("ovf_set", {31'd0, ovf_sticky}, 32'd1);
      push_byte(8'h5A);
      exp_q.push_back(ev(8'h5A, 0, 1, 8'd0));
      n = 0;
      while (dbg_state != 2'd2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("gap_seen", {30'd0, dbg_state}, 32'd2);
      clr = 1'b1;
      overflow = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      overflow = 1'b0;
      chk("clr_cnt", {24'd0, press_cnt}, 32'd0);
      chk("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
      chk("clr_keeps_key", {23'd0, scan_code, key_down}, {23'd0, 8'h5A, 1'b1});
      wait_drain("clr_gap", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
